uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx.sv | 159 +++++++++++++++
 tb/tb_uart_byte_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: start-bit validation at half bit, mid-bit sampling,
// stop-bit check with break recovery, and idle-gap detection after a byte.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int CLK_DIV  = 868,
  parameter int GAP_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] frame_data_in,
  output logic       frame_data_ena,
  output logic       frame_err,
  output logic       frame_gap,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_BITS * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_M1  = GAP_W'(GAP_BITS * CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_BITS * CLK_DIV);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ena_q, ena_d;
  logic             err_q, err_d;
  logic             gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             armed_q, armed_d;
  logic             rxd_meta_q, rxd_s_q, rxd_d_q;

  // The line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_d_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_d_q    <= rxd_s_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ena_q     <= 1'b0;
      err_q     <= 1'b0;
      gap_q     <= 1'b0;
      gap_cnt_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ena_q     <= ena_d;
      err_q     <= err_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      armed_q   <= armed_d;
    end
  end

  // Strobes come from the STOP branch (ena/err) or the IDLE branch (gap) only,
  // so at most one of them is set for any given cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ena_d     = 1'b0;
    err_d     = 1'b0;
    gap_d     = 1'b0;
    gap_cnt_d = gap_cnt_q;
    armed_d   = armed_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxd_d_q && !rxd_s_q) begin
          state_d   = START;
          gap_cnt_d = '0;
        end else if (rxd_s_q) begin
          if (gap_cnt_q != GAP_MAX) gap_cnt_d = gap_cnt_q + GAP_W'(1);
          if (armed_q && (gap_cnt_q == GAP_M1)) begin
            gap_d   = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            data_d  = shift_q;
            ena_d   = 1'b1;
            armed_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign frame_data_in  = data_q;
  assign frame_data_ena = ena_q;
  assign frame_err      = err_q;
  assign frame_gap      = gap_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at CLK_DIV=16, GAP_BITS=4: a bit-accurate line
// driver, a strobe monitor feeding a received-byte queue, and immediate-assert checks.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int CLK_DIV  = 16;
  localparam int GAP_BITS = 4;
  localparam int P_NOM    = 1600;
  localparam int P_FAST   = 1552;
  localparam int P_SLOW   = 1648;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  logic [7:0] frame_data_in;
  logic       frame_data_ena;
  logic       frame_err;
  logic       frame_gap;
  logic       busy;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int ena_cnt = 0, err_cnt = 0, gap_cnt = 0;
  int long_cnt = 0, multi_cnt = 0;
  int busy_run = 0, busy_last_run = 0;
  int ena_cyc = 0, gap_cyc = 0;
  logic ena_p = 1'b0, err_p = 1'b0, gap_p = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_byte_rx #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rxd       (uart_rxd),
    .frame_data_in  (frame_data_in),
    .frame_data_ena (frame_data_ena),
    .frame_err      (frame_err),
    .frame_gap      (frame_gap),
    .busy           (busy),
    .dbg_state_o    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_data_ena) begin
        ena_cnt++;
        ena_cyc = cyc;
        got_q.push_back(frame_data_in);
      end
      if (frame_err) err_cnt++;
      if (frame_gap) begin
        gap_cnt++;
        gap_cyc = cyc;
      end
      if ((frame_data_ena && ena_p) || (frame_err && err_p) || (frame_gap && gap_p)) long_cnt++;
      if ((int'(frame_data_ena) + int'(frame_err) + int'(frame_gap)) > 1) multi_cnt++;
      if (busy) busy_run++;
      else begin
        if (busy_run != 0) busy_last_run = busy_run;
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
    ena_p = frame_data_ena;
    err_p = frame_err;
    gap_p = frame_gap;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit period in hundredths of a clock so that small skews accumulate correctly.
  task automatic send_byte(input logic [7:0] d, input int per_x100, input logic stop_v,
                           input int stop_bits);
    int elapsed;
    int tgt;
    int nb;
    elapsed = 0;
    nb = 9 + stop_bits;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) uart_rxd = 1'b0;
      else if (k <= 8) uart_rxd = d[k-1];
      else uart_rxd = stop_v;
      tgt = ((k + 1) * per_x100) / 100;
      tick(tgt - elapsed);
      elapsed = tgt;
    end
    uart_rxd = 1'b1;
  endtask

  // scoreboard drain: every expected byte must match the next received byte
  task automatic drain(input string tag);
    logic [7:0] e;
    logic [8:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = {1'b0, got_q.pop_front()};
      else g = 9'h100;
      check(tag, 32'(g), 32'(e));
    end
    check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
  endtask

  int e0, r0, g0, t0, lat;
  logic [7:0] b;

  initial begin
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    tick(3);
    check("rst_data", 32'(frame_data_in), 32'h00);
    check("rst_ena", 32'(frame_data_ena), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_gap", 32'(frame_gap), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // no gap before the first byte
    rst_n = 1'b1;
    tick(100);
    check("gap_disarmed", 32'(gap_cnt), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);

    // two back-to-back bytes
    e0 = ena_cnt; r0 = err_cnt;
    exp_q.push_back(8'hEB);
    exp_q.push_back(8'h9C);
    t0 = cyc;
    send_byte(8'hEB, P_NOM, 1'b1, 1);
    lat = ena_cyc - t0;
    check("latency_ok", 32'(lat >= 154 && lat <= 156), 32'd1);
    send_byte(8'h9C, P_NOM, 1'b1, 1);
    tick(20);
    check("b2b_ena_cnt", 32'(ena_cnt - e0), 32'd2);
    check("b2b_err_cnt", 32'(err_cnt - r0), 32'd0);
    drain("b2b_byte");
    check("b2b_hold", 32'(frame_data_in), 32'h9C);

    // stop bit low for two bit times, then a clean byte
    e0 = ena_cnt; r0 = err_cnt;
    send_byte(8'h55, P_NOM, 1'b0, 2);
    tick(8);
    check("ferr_err_cnt", 32'(err_cnt - r0), 32'd1);
    check("ferr_no_ena", 32'(ena_cnt - e0), 32'd0);
    check("ferr_data_kept", 32'(frame_data_in), 32'h9C);
    check("ferr_back_idle", 32'(dbg_state), 32'd0);
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, P_NOM, 1'b1, 1);
    tick(10);
    check("after_err_ena", 32'(ena_cnt - e0), 32'd1);
    drain("after_err_byte");

    // short low glitch on the idle line
    e0 = ena_cnt; r0 = err_cnt; g0 = gap_cnt;
    busy_last_run = 0;
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(20);
    check("glitch_no_ena", 32'(ena_cnt - e0), 32'd0);
    check("glitch_no_err", 32'(err_cnt - r0), 32'd0);
    check("glitch_no_gap", 32'(gap_cnt - g0), 32'd0);
    check("glitch_busy_len", 32'(busy_last_run >= 1 && busy_last_run <= 8), 32'd1);
    check("glitch_idle", 32'(busy), 32'd0);

    // idle gap after a byte: one pulse only
    e0 = ena_cnt; g0 = gap_cnt;
    exp_q.push_back(8'h01);
    send_byte(8'h01, P_NOM, 1'b1, 1);
    tick(200);
    check("gap_ena", 32'(ena_cnt - e0), 32'd1);
    check("gap_once", 32'(gap_cnt - g0), 32'd1);
    check("gap_delay", 32'((gap_cyc - ena_cyc) >= 63 && (gap_cyc - ena_cyc) <= 65), 32'd1);
    drain("gap_byte");

    // reset during bit 4 of 0xFF
    e0 = ena_cnt; g0 = gap_cnt;
    uart_rxd = 1'b0;
    tick(16);
    uart_rxd = 1'b1;
    tick(72);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(3);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(frame_data_in), 32'h00);
    rst_n = 1'b1;
    tick(100);
    check("mid_rst_no_ena", 32'(ena_cnt - e0), 32'd0);
    check("mid_rst_disarmed", 32'(gap_cnt - g0), 32'd0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, P_NOM, 1'b1, 1);
    tick(10);
    check("post_rst_ena", 32'(ena_cnt - e0), 32'd1);
    drain("post_rst_byte");

    // ten random bytes with +/-3% bit period skew
    e0 = ena_cnt; r0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, (i % 2 == 0) ? P_SLOW : P_FAST, 1'b1, 1);
    end
    tick(20);
    check("skew_ena_cnt", 32'(ena_cnt - e0), 32'd10);
    check("skew_err_cnt", 32'(err_cnt - r0), 32'd0);
    drain("skew_byte");

    check("strobe_width", 32'(long_cnt), 32'd0);
    check("strobe_exclusive", 32'(multi_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
